// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN TX constants, frame-word field map, state encoding
package can_pkg;

    localparam int FRAME_W     = 128;

    localparam int ID_LSB      = 0;
    localparam int ID_W        = 29;
    localparam int STD_ID_W    = 11;
    localparam int IDE_BIT     = 29;
    localparam int RTR_BIT     = 30;
    localparam int DLC_LSB     = 31;
    localparam int DLC_W       = 4;
    localparam int DATA_LSB    = 64;
    localparam int DATA_W      = 64;

    localparam int CAN_DLC_MAX = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_REQ    = 3'd3,
        ST_ACTIVE = 3'd4
    } tx_state_e;

    // DLC codes 9..15 still mean eight data bytes on the wire.
    function automatic logic [3:0] dlc_to_len(input logic [3:0] dlc);
        return (dlc > 4'(CAN_DLC_MAX)) ? 4'(CAN_DLC_MAX) : dlc;
    endfunction

endpackage

// File: rtl/can_tx_loader_if.sv
// rtl/can_tx_loader_if.sv - FIFO / bit-engine / status bundle for can_tx_loader
//
// master: the loader side (drives o_*); slave: FIFO + bit engine + host side.
//   i_fifo_r_data, i_fifo_empty, o_fifo_r_en  : TX FIFO read port
//   o_tx_req, i_tx_ack, i_tx_done,
//   i_tx_arb_lost, i_tx_error                 : bit engine handshake
//   o_tx_id/ide/rtr/dlc/data                  : unpacked frame fields
//   o_busy, o_tx_ok, o_tx_abort, o_retry_cnt  : status
interface can_tx_loader_if #(
    parameter int MAX_RETRIES = 8
);
    import can_pkg::*;

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic [FRAME_W-1:0] i_fifo_r_data;
    logic               i_fifo_empty;
    logic               o_fifo_r_en;
    logic               o_tx_req;
    logic               i_tx_ack;
    logic               i_tx_done;
    logic               i_tx_arb_lost;
    logic               i_tx_error;
    logic [ID_W-1:0]    o_tx_id;
    logic               o_tx_ide;
    logic               o_tx_rtr;
    logic [DLC_W-1:0]   o_tx_dlc;
    logic [DATA_W-1:0]  o_tx_data;
    logic               o_busy;
    logic               o_tx_ok;
    logic               o_tx_abort;
    logic [RETRY_W-1:0] o_retry_cnt;

    modport master (
        input  i_fifo_r_data, i_fifo_empty, i_tx_ack, i_tx_done, i_tx_arb_lost, i_tx_error,
        output o_fifo_r_en, o_tx_req, o_tx_id, o_tx_ide, o_tx_rtr, o_tx_dlc, o_tx_data,
               o_busy, o_tx_ok, o_tx_abort, o_retry_cnt
    );

    modport slave (
        output i_fifo_r_data, i_fifo_empty, i_tx_ack, i_tx_done, i_tx_arb_lost, i_tx_error,
        input  o_fifo_r_en, o_tx_req, o_tx_id, o_tx_ide, o_tx_rtr, o_tx_dlc, o_tx_data,
               o_busy, o_tx_ok, o_tx_abort, o_retry_cnt
    );

endinterface

// File: rtl/can_tx_frame_unpack.sv
// rtl/can_tx_frame_unpack.sv - combinational frame-word field extraction and masking
//
// Ports:
//   word  in  DATA_WIDTH  raw TX FIFO word
//   id    out 29          ID (bits [28:11] zeroed for standard frames)
//   ide   out 1           extended-ID flag
//   rtr   out 1           remote frame flag
//   dlc   out 4           DLC as stored in the word
//   data  out 64          payload, bytes beyond min(DLC,8) and all bytes of RTR frames zeroed
module can_tx_frame_unpack
    import can_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic [DATA_WIDTH-1:0] word,
    output logic [ID_W-1:0]       id,
    output logic                  ide,
    output logic                  rtr,
    output logic [DLC_W-1:0]      dlc,
    output logic [DATA_W-1:0]     data
);

    logic [3:0] len;

    // Reserved word bits [63:35] carry nothing for transmission.
    logic unused_rsvd;
    assign unused_rsvd = ^word[DATA_LSB-1:DLC_LSB+DLC_W];

    always_comb begin
        ide  = word[IDE_BIT];
        rtr  = word[RTR_BIT];
        dlc  = word[DLC_LSB +: DLC_W];
        id   = word[ID_LSB +: ID_W];
        if (!ide) begin
            id[ID_W-1:STD_ID_W] = '0;
        end
        len  = dlc_to_len(dlc);
        data = '0;
        for (int k = 0; k < CAN_DLC_MAX; k++) begin
            if (!rtr && (4'(k) < len)) begin
                data[8*k +: 8] = word[DATA_LSB + 8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/can_tx_loader.sv
// rtl/can_tx_loader.sv - pops TX FIFO frames and hands them to the CAN bit engine with retry
//
// Ports:
//   i_sys_clk  in  system clock
//   i_reset    in  synchronous active-high reset
//   bus        can_tx_loader_if.master (FIFO read, bit-engine handshake, frame fields, status)
//
// Build option: CAN_TX_RETRY_LIMIT_EN - abort a frame once bus errors reach MAX_RETRIES;
// without it frames are retried forever and o_tx_abort is constant 0.
module can_tx_loader
    import can_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int MAX_RETRIES = 8
) (
    input  logic           i_sys_clk,
    input  logic           i_reset,
    can_tx_loader_if.master bus
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] POP    = ST_POP;
    localparam logic [2:0] LOAD   = ST_LOAD;
    localparam logic [2:0] REQ    = ST_REQ;
    localparam logic [2:0] ACTIVE = ST_ACTIVE;

    logic [2:0]         state;
    logic [ID_W-1:0]    tx_id_q;
    logic               tx_ide_q;
    logic               tx_rtr_q;
    logic [DLC_W-1:0]   tx_dlc_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic               tx_ok_q;
    logic [RETRY_W-1:0] retry_cnt_q;

    logic [ID_W-1:0]    u_id;
    logic               u_ide;
    logic               u_rtr;
    logic [DLC_W-1:0]   u_dlc;
    logic [DATA_W-1:0]  u_data;

    logic [RETRY_W-1:0] retry_inc;
    logic               limit_hit;

    can_tx_frame_unpack #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_unpack (
        .word (bus.i_fifo_r_data),
        .id   (u_id),
        .ide  (u_ide),
        .rtr  (u_rtr),
        .dlc  (u_dlc),
        .data (u_data)
    );

    assign retry_inc = (retry_cnt_q == RETRY_SAT) ? retry_cnt_q : retry_cnt_q + 1'b1;

`ifdef CAN_TX_RETRY_LIMIT_EN
    logic tx_abort_q;
    assign limit_hit      = (retry_inc == RETRY_W'(MAX_RETRIES));
    assign bus.o_tx_abort = tx_abort_q;
`else
    assign limit_hit      = 1'b0;
    assign bus.o_tx_abort = 1'b0;
`endif

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            tx_id_q     <= '0;
            tx_ide_q    <= 1'b0;
            tx_rtr_q    <= 1'b0;
            tx_dlc_q    <= '0;
            tx_data_q   <= '0;
            tx_ok_q     <= 1'b0;
            retry_cnt_q <= '0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            tx_abort_q  <= 1'b0;
`endif
        end else begin
            tx_ok_q <= 1'b0;
`ifdef CAN_TX_RETRY_LIMIT_EN
            tx_abort_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!bus.i_fifo_empty) begin
                        state <= POP;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                // FIFO read data lands in this cycle, one after the pop strobe.
                LOAD: begin
                    tx_id_q     <= u_id;
                    tx_ide_q    <= u_ide;
                    tx_rtr_q    <= u_rtr;
                    tx_dlc_q    <= u_dlc;
                    tx_data_q   <= u_data;
                    retry_cnt_q <= '0;
                    state       <= REQ;
                end
                // Completion/error strobes are meaningless until the engine has taken the frame.
                REQ: begin
                    if (bus.i_tx_ack) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.i_tx_done) begin
                        tx_ok_q <= 1'b1;
                        state   <= IDLE;
                    end else if (bus.i_tx_error) begin
                        retry_cnt_q <= retry_inc;
                        state       <= limit_hit ? IDLE : REQ;
`ifdef CAN_TX_RETRY_LIMIT_EN
                        tx_abort_q  <= limit_hit;
`endif
                    end else if (bus.i_tx_arb_lost) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_fifo_r_en = (state == POP);
    assign bus.o_tx_req    = (state == REQ);
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_tx_ok     = tx_ok_q;
    assign bus.o_retry_cnt = retry_cnt_q;
    assign bus.o_tx_id     = tx_id_q;
    assign bus.o_tx_ide    = tx_ide_q;
    assign bus.o_tx_rtr    = tx_rtr_q;
    assign bus.o_tx_dlc    = tx_dlc_q;
    assign bus.o_tx_data   = tx_data_q;

endmodule

// File: tb/tb_can_tx_loader.sv
// tb/tb_can_tx_loader.sv - self-checking bench for can_tx_loader
module tb_can_tx_loader;

    localparam int MAXR = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    can_tx_loader_if #(.MAX_RETRIES(MAXR)) bus ();

    can_tx_loader #(
        .DATA_WIDTH  (128),
        .MAX_RETRIES (MAXR)
    ) dut (
        .i_sys_clk (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // FIFO model: bench pushes into push_mem; negedge process serves pops with one-cycle read latency.
    logic [127:0] push_mem [0:63];
    int           push_cnt  = 0;
    int           rd_idx    = 0;
    logic [127:0] pend_word;
    bit           have_pend = 0;
    int           pop_cnt   = 0;
    int           ok_cnt    = 0;
    int           abort_cnt = 0;
    int           req_phases = 0;
    logic         req_q     = 1'b0;

    always @(negedge clk) begin
        if (bus.o_tx_ok === 1'b1)    ok_cnt++;
        if (bus.o_tx_abort === 1'b1) abort_cnt++;
        if (bus.o_tx_req === 1'b1 && req_q !== 1'b1) req_phases++;
        req_q = bus.o_tx_req;
        if (have_pend) begin
            bus.i_fifo_r_data = pend_word;
            have_pend = 0;
        end
        if (bus.o_fifo_r_en === 1'b1) begin
            pop_cnt++;
            if (rd_idx < push_cnt) begin
                pend_word = push_mem[rd_idx];
                rd_idx++;
                have_pend = 1;
            end
        end
        bus.i_fifo_empty = (rd_idx == push_cnt);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] w);
        push_mem[push_cnt] = w;
        push_cnt++;
    endtask

    function automatic logic [28:0] model_id(input logic [127:0] w);
        logic [28:0] id;
        id = w[28:0];
        if (w[29] == 1'b0) id = id % 29'd2048;
        return id;
    endfunction

    function automatic logic [63:0] model_data(input logic [127:0] w);
        int          len;
        logic [63:0] d;
        len = (w[34:31] > 4'd8) ? 8 : int'(w[34:31]);
        if (w[30]) return 64'd0;
        d = w[127:64];
        if (len < 8) d = d & ((64'd1 << (8 * len)) - 64'd1);
        return d;
    endfunction

    task automatic check_fields(input string tag, input logic [127:0] w);
        check({tag, "_id"},   128'(bus.o_tx_id),   128'(model_id(w)));
        check({tag, "_ide"},  128'(bus.o_tx_ide),  128'(w[29]));
        check({tag, "_rtr"},  128'(bus.o_tx_rtr),  128'(w[30]));
        check({tag, "_dlc"},  128'(bus.o_tx_dlc),  128'(w[34:31]));
        check({tag, "_data"}, 128'(bus.o_tx_data), 128'(model_data(w)));
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.o_tx_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, 128'(bus.o_tx_req), 128'(1));
    endtask

    task automatic do_ack();
        bus.i_tx_ack = 1'b1;
        tick();
        bus.i_tx_ack = 1'b0;
    endtask

    task automatic pulse_done(input string tag);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        check({tag, "_ok"},   128'(bus.o_tx_ok),  128'(1));
        check({tag, "_idle"}, 128'(bus.o_busy),   128'(0));
        tick();
        check({tag, "_ok_1cyc"}, 128'(bus.o_tx_ok), 128'(0));
    endtask

    function automatic logic [127:0] mkword(input logic [28:0] id, input logic ide, input logic rtr,
                                            input logic [3:0] dlc, input logic [63:0] data);
        logic [127:0] w;
        w = '0;
        w[28:0]   = id;
        w[29]     = ide;
        w[30]     = rtr;
        w[34:31]  = dlc;
        w[127:64] = data;
        return w;
    endfunction

    initial begin
        logic [127:0] w;
        int ph0, ok0, pop0, ab0, n_arb;

        rst = 1'b1;
        bus.i_tx_ack = 1'b0;
        bus.i_tx_done = 1'b0;
        bus.i_tx_arb_lost = 1'b0;
        bus.i_tx_error = 1'b0;

        // Reset with a frame already waiting.
        w = mkword(29'h123, 1'b0, 1'b0, 4'd2, 64'h8877665544332211);
        push(w);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_r_en", 128'(bus.o_fifo_r_en), 128'(0));
        end
        check("rst_outputs", {bus.o_tx_req, bus.o_busy, bus.o_tx_ok, bus.o_tx_abort, bus.o_retry_cnt,
                              bus.o_tx_id, bus.o_tx_ide, bus.o_tx_rtr, bus.o_tx_dlc, bus.o_tx_data}, 128'(0));
        ok0 = ok_cnt; pop0 = pop_cnt;
        rst = 1'b0;
        check("first_pop_not_early", 128'(bus.o_fifo_r_en), 128'(0));
        tick();
        check("first_pop", 128'(bus.o_fifo_r_en), 128'(1));
        tick();
        check("pop_one_cycle", 128'(bus.o_fifo_r_en), 128'(0));
        check("req_not_n2", 128'(bus.o_tx_req), 128'(0));
        tick();
        check("req_n3", 128'(bus.o_tx_req), 128'(1));
        check("f1_id_lit", 128'(bus.o_tx_id), 128'(29'h123));
        check("f1_data_lit", 128'(bus.o_tx_data), 128'(64'h2211));
        check_fields("f1", w);
        do_ack();
        check("f1_active_no_req", 128'(bus.o_tx_req), 128'(0));
        check("f1_active_busy", 128'(bus.o_busy), 128'(1));
        pulse_done("f1");
        check("f1_ok_count", 128'(ok_cnt - ok0), 128'(1));
        check("f1_single_pop", 128'(pop_cnt - pop0), 128'(1));

        // DLC above 8 keeps the code but caps the payload; REQ ignores completion strobes.
        w = mkword(29'h1ABCDEF5, 1'b1, 1'b0, 4'd12, 64'hFFFFFFFFFFFFFFFF);
        ok0 = ok_cnt;
        push(w);
        wait_req("f2");
        check("f2_dlc", 128'(bus.o_tx_dlc), 128'(12));
        check("f2_data", 128'(bus.o_tx_data), 128'(64'hFFFFFFFFFFFFFFFF));
        check_fields("f2", w);
        bus.i_tx_done = 1'b1; bus.i_tx_error = 1'b1; bus.i_tx_arb_lost = 1'b1;
        tick();
        bus.i_tx_done = 1'b0; bus.i_tx_error = 1'b0; bus.i_tx_arb_lost = 1'b0;
        check("req_ignores_req", 128'(bus.o_tx_req), 128'(1));
        check("req_ignores_ok", 128'(bus.o_tx_ok), 128'(0));
        check("req_ignores_retry", 128'(bus.o_retry_cnt), 128'(0));
        do_ack();
        pulse_done("f2");
        check("f2_ok_count", 128'(ok_cnt - ok0), 128'(1));

        w[30] = 1'b1;
        push(w);
        wait_req("f3");
        check("f3_rtr_data", 128'(bus.o_tx_data), 128'(0));
        check_fields("f3", w);
        do_ack();
        pulse_done("f3");

        // Random frames with random arbitration losses.
        for (int i = 0; i < 12; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            n_arb = $urandom_range(0, 3);
            ph0 = req_phases; ok0 = ok_cnt; pop0 = pop_cnt;
            push(w);
            wait_req("rnd");
            check_fields("rnd", w);
            for (int a = 0; a < n_arb; a++) begin
                do_ack();
                bus.i_tx_arb_lost = 1'b1;
                tick();
                bus.i_tx_arb_lost = 1'b0;
                check("rnd_arb_back_req", 128'(bus.o_tx_req), 128'(1));
            end
            check_fields("rnd_held", w);
            do_ack();
            pulse_done("rnd");
            check("rnd_phases", 128'(req_phases - ph0), 128'(n_arb + 1));
            check("rnd_retry", 128'(bus.o_retry_cnt), 128'(0));
            check("rnd_ok_count", 128'(ok_cnt - ok0), 128'(1));
            check("rnd_pops", 128'(pop_cnt - pop0), 128'(1));
        end

        // Bus errors up to the retry limit.
        w = mkword(29'h055, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF);
        ph0 = req_phases; ab0 = abort_cnt; ok0 = ok_cnt;
        push(w);
        wait_req("err");
        for (int e = 1; e <= MAXR; e++) begin
            do_ack();
            bus.i_tx_error = 1'b1;
            tick();
            bus.i_tx_error = 1'b0;
            check("err_retry_cnt", 128'(bus.o_retry_cnt), 128'(e));
`ifdef CAN_TX_RETRY_LIMIT_EN
            if (e == MAXR) begin
                check("err_abort", 128'(bus.o_tx_abort), 128'(1));
                check("err_abort_idle", 128'(bus.o_busy), 128'(0));
                tick();
                check("err_abort_1cyc", 128'(bus.o_tx_abort), 128'(0));
            end else begin
                check("err_back_req", 128'(bus.o_tx_req), 128'(1));
            end
`else
            check("err_back_req", 128'(bus.o_tx_req), 128'(1));
            check("err_no_abort", 128'(bus.o_tx_abort), 128'(0));
`endif
        end
        tick();
`ifdef CAN_TX_RETRY_LIMIT_EN
        check("err_phases", 128'(req_phases - ph0), 128'(MAXR));
        check("err_abort_count", 128'(abort_cnt - ab0), 128'(1));
        check("err_no_ok", 128'(ok_cnt - ok0), 128'(0));
`else
        check("err_phases", 128'(req_phases - ph0), 128'(MAXR + 1));
        for (int e = 0; e < 2; e++) begin
            do_ack();
            bus.i_tx_error = 1'b1;
            tick();
            bus.i_tx_error = 1'b0;
            check("err_saturate", 128'(bus.o_retry_cnt), 128'(3));
        end
        do_ack();
        pulse_done("err");
        check("err_abort_count", 128'(abort_cnt - ab0), 128'(0));
`endif

        // Done and error together: done wins, counter holds.
        w = mkword(29'h2AA, 1'b0, 1'b0, 4'd1, 64'hA5);
        ok0 = ok_cnt;
        push(w);
        wait_req("sim");
        do_ack();
        bus.i_tx_error = 1'b1;
        tick();
        bus.i_tx_error = 1'b0;
        check("sim_retry_1", 128'(bus.o_retry_cnt), 128'(1));
        do_ack();
        bus.i_tx_done = 1'b1; bus.i_tx_error = 1'b1;
        tick();
        bus.i_tx_done = 1'b0; bus.i_tx_error = 1'b0;
        check("sim_ok", 128'(bus.o_tx_ok), 128'(1));
        check("sim_retry_held", 128'(bus.o_retry_cnt), 128'(1));
        tick();
        check("sim_ok_count", 128'(ok_cnt - ok0), 128'(1));

        // Reset while the frame is on the bus.
        w = mkword(29'h7FF, 1'b0, 1'b0, 4'd4, 64'h11223344);
        push(w);
        wait_req("rma");
        do_ack();
        ok0 = ok_cnt; ab0 = abort_cnt; pop0 = pop_cnt;
        rst = 1'b1;
        tick();
        check("rma_outputs", {bus.o_fifo_r_en, bus.o_tx_req, bus.o_busy, bus.o_tx_ok, bus.o_tx_abort,
                              bus.o_retry_cnt, bus.o_tx_id, bus.o_tx_ide, bus.o_tx_rtr, bus.o_tx_dlc,
                              bus.o_tx_data}, 128'(0));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rma_discard_idle", 128'(bus.o_busy), 128'(0));
        check("rma_no_ok", 128'(ok_cnt - ok0), 128'(0));
        check("rma_no_abort", 128'(abort_cnt - ab0), 128'(0));
        check("rma_no_pop", 128'(pop_cnt - pop0), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
